// File: rtl/eth_frame_receiver_if.sv
// Byte-stream input and decoded-frame outputs of the Ethernet frame receiver.
// The receiver takes the slave side; the source and sink take the master side.
interface eth_frame_receiver_if;
    logic [7:0]  frame_in;
    logic        frame_valid;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        hdr_valid;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic        addr_miss;

    modport slave (
        input  frame_in, frame_valid,
        output dst_mac, src_mac, ethertype, hdr_valid, pay_data, pay_valid,
               frame_done, frame_ok, crc_err, len_err, addr_miss
    );

    modport master (
        output frame_in, frame_valid,
        input  dst_mac, src_mac, ethertype, hdr_valid, pay_data, pay_valid,
               frame_done, frame_ok, crc_err, len_err, addr_miss
    );
endinterface

// File: rtl/eth_frame_receiver.sv
// Byte-wide Ethernet receiver: preamble/SFD delineation, header extraction,
// FCS-stripped payload streaming and CRC/length/address status per frame.
module eth_frame_receiver #(
    parameter logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01,
    parameter bit          PROMISC = 1'b0,
    parameter int unsigned MAX_LEN = 1518
) (
    input logic               clk,
    input logic               rst_n,
    eth_frame_receiver_if.slave bus
);

    typedef enum logic [2:0] {IDLE, PRE, HDR, BODY, DONE, DROP} state_t;

    localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);

    state_t       state;
    logic [2:0]   pre_cnt;
    logic [10:0]  cnt;
    logic [31:0]  crc;
    logic [111:0] hdr;
    logic [31:0]  line;
    logic [2:0]   fill;

    logic         hdr_valid, pay_valid, frame_done, frame_ok;
    logic         crc_err, len_err, addr_miss;
    logic [7:0]   pay_data;

    logic [31:0]  crc_upd;
    logic [10:0]  cnt_inc;
    logic         crc_bad, len_bad, addr_bad;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        crc_upd  = crc_next(crc, bus.frame_in);
        cnt_inc  = (cnt == '1) ? cnt : cnt + 11'd1;
        crc_bad  = (crc != 32'hDEBB_20E3);
        len_bad  = (cnt < 11'd64) || (cnt > MAX_CNT);
        addr_bad = !PROMISC && (hdr[111:64] != MY_MAC) && (hdr[111:64] != '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            cnt        <= '0;
            crc        <= '1;
            hdr        <= '0;
            line       <= '0;
            fill       <= '0;
            hdr_valid  <= 1'b0;
            pay_valid  <= 1'b0;
            pay_data   <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            addr_miss  <= 1'b0;
        end else begin
            hdr_valid  <= 1'b0;
            pay_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            addr_miss  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.frame_valid) begin
                        if (bus.frame_in == 8'h55) begin
                            state   <= PRE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                PRE: begin
                    if (!bus.frame_valid) begin
                        state <= DROP;
                    end else if (bus.frame_in == 8'hD5) begin
                        state <= HDR;
                        cnt   <= '0;
                        crc   <= '1;
                        fill  <= '0;
                    end else if (bus.frame_in == 8'h55 && pre_cnt != 3'd7) begin
                        pre_cnt <= pre_cnt + 3'd1;
                    end else begin
                        state <= DROP;
                    end
                end
                HDR, BODY: begin
                    if (bus.frame_valid) begin
                        cnt <= cnt_inc;
                        crc <= crc_upd;
                        if (state == HDR) begin
                            hdr <= {hdr[103:0], bus.frame_in};
                            if (cnt == 11'd13) begin
                                state     <= BODY;
                                hdr_valid <= 1'b1;
                            end
                        end else begin
                            // Four-byte line holds back the FCS; only a full line releases its oldest byte.
                            line <= {line[23:0], bus.frame_in};
                            if (fill == 3'd4) begin
                                pay_valid <= 1'b1;
                                pay_data  <= line[31:24];
                            end else begin
                                fill <= fill + 3'd1;
                            end
                        end
                    end else begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        crc_err    <= crc_bad;
                        len_err    <= len_bad;
                        addr_miss  <= addr_bad;
                        frame_ok   <= !(crc_bad || len_bad || addr_bad);
                    end
                end
                DONE: state <= IDLE;
                DROP: if (!bus.frame_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dst_mac    = hdr[111:64];
    assign bus.src_mac    = hdr[63:16];
    assign bus.ethertype  = hdr[15:0];
    assign bus.hdr_valid  = hdr_valid;
    assign bus.pay_data   = pay_data;
    assign bus.pay_valid  = pay_valid;
    assign bus.frame_done = frame_done;
    assign bus.frame_ok   = frame_ok;
    assign bus.crc_err    = crc_err;
    assign bus.len_err    = len_err;
    assign bus.addr_miss  = addr_miss;

endmodule
